// File: rtl/water_level_sensor_driver_if.sv
// Sensor-side bundle for the tank level driver.
// The commander drives fill/drain; the driver returns level, sensor word and flags.
interface water_level_sensor_driver_if;
   logic       fill;
   logic       drain;
   logic [7:0] a;
   logic [2:0] level;
   logic       level_chg;
   logic       overflow;
   logic       underflow;

   modport master (
      output fill, drain,
      input  a, level, level_chg, overflow, underflow
   );

   modport slave (
      input  fill, drain,
      output a, level, level_chg, overflow, underflow
   );
endinterface

// File: rtl/water_level_sensor_driver.sv
// Tank model: prescaled fill/drain stepping of a 3-bit level,
// with a one-hot sensor word and sticky over/underflow flags.
module water_level_sensor_driver #(
   parameter int unsigned TICK_DIV = 4
) (
   input logic                        clk,
   input logic                        rst,
   water_level_sensor_driver_if.slave bus
);
   localparam int unsigned PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e        state_q, state_d, cmd;
   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    level_q, level_d;
   logic [7:0]    a_q, a_d;
   logic          chg_q, chg_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         level_q <= 3'd0;
         a_q     <= 8'd1;
         chg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         level_q <= level_d;
         a_q     <= a_d;
         chg_q   <= chg_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_comb begin
      cmd     = IDLE;
      state_d = state_q;
      pre_d   = '0;
      step    = 1'b0;
      level_d = level_q;
      chg_d   = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      // Both commands at once cancel out to IDLE
      if (bus.fill && !bus.drain) begin
         cmd = FILL;
      end else if (bus.drain && !bus.fill) begin
         cmd = DRAIN;
      end
      state_d = cmd;

      if (cmd == state_q && state_q != IDLE) begin
         if (pre_q == LAST) begin
            step = 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end

      if (step) begin
         unique case (state_q)
            FILL: begin
               if (level_q != 3'd7) begin
                  level_d = level_q + 3'd1;
                  chg_d   = 1'b1;
                  unf_d   = 1'b0;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            DRAIN: begin
               if (level_q != 3'd0) begin
                  level_d = level_q - 3'd1;
                  chg_d   = 1'b1;
                  ovf_d   = 1'b0;
               end else begin
                  unf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Word tracks the next level so it lands on the same edge
      a_d = 8'd1 << level_d;
   end

   assign bus.a         = a_q;
   assign bus.level     = level_q;
   assign bus.level_chg = chg_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
endmodule

// File: doc/water_level_sensor_driver.md
# water_level_sensor_driver

Sequential driver for the 8-bit level-sensor word read by the tank's full/half/empty water-level encoder. It keeps a 3-bit tank level that rises or falls one step at a time, at a prescaled rate, under fill and drain commands. It drives the matching one-hot sensor word, where bit 0 means empty, bit 4 means half and bit 7 means full. It is the stimulus-side end of the sensor interface: it serves as the tank model for the encoder bench, and as the LED-bar / sensor emulator on the board build.

## Interface
- `TICK_DIV`, default 4: clock cycles per level step. Legal range is 1 to 255. The prescaler is `$clog2(TICK_DIV+1)` bits wide.
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `fill`, input, 1 bit: request to raise the level. Level-sensitive.
- `drain`, input, 1 bit: request to lower the level. Level-sensitive.
- `a`, output, 8 bits: one-hot sensor word, `a = 8'b1 << level`. Registered.
- `level`, output, 3 bits: current level, 0 (empty) to 7 (full). Registered.
- `level_chg`, output, 1 bit: one-cycle pulse on the edge where `level` changes.
- `overflow`, output, 1 bit: sticky. Set when a fill step is attempted while `level` is 7.
- `underflow`, output, 1 bit: sticky. Set when a drain step is attempted while `level` is 0.

## Operation
- **Reset values** (asynchronous, while `rst`=1):
  - `level`=0, `a`=8'b00000001.
  - `level_chg`=0, `overflow`=0, `underflow`=0.
  - State is IDLE; prescaler is 0.
- **Command decode**, evaluated every edge:
  - `fill`=1 and `drain`=0 gives FILL.
  - `drain`=1 and `fill`=0 gives DRAIN.
  - Both 0, or both 1, gives IDLE. Simultaneous commands cancel each other and are not an error.
- **States:** IDLE, FILL, DRAIN.
  - The state register loads the decoded command on every edge.
  - Every transition is legal, including FILL to DRAIN directly.
- **Prescaler:**
  - Cleared to 0 on any edge where the decoded command differs from the current state, and on every edge in IDLE.
  - Otherwise, if prescaler equals `TICK_DIV-1`, it wraps to 0 and a step fires. If not, it increments by 1.
- **Step in FILL:**
  - If `level` is below 7: `level` increments by 1 and `level_chg` pulses.
  - If `level` is 7: `level` holds, `level_chg` stays 0 and `overflow` is set.
- **Step in DRAIN:**
  - If `level` is above 0: `level` decrements by 1 and `level_chg` pulses.
  - If `level` is 0: `level` holds, `level_chg` stays 0 and `underflow` is set.
- **Flag clearing:**
  - `overflow` clears on the next successful drain step.
  - `underflow` clears on the next successful fill step.
  - Both flags also clear on `rst`. Nothing else clears them.
- **Sensor word:** `a` is always exactly one-hot and always equals `1 << level`, including during reset. It is never all-zero. Level 4 gives the half code 8'b00010000.
- **Arithmetic:** `level` saturates at 7 and 0 and never wraps.

## Timing
- **Step latency:** a command first sampled at edge k causes its first step at edge k+`TICK_DIV`. The step repeats every `TICK_DIV` edges while the command stays stable.
- **`TICK_DIV`=1:** steps occur on every edge from k+1.
- **Output alignment:** `level`, `a`, `level_chg`, `overflow` and `underflow` all update on the step edge. There is zero added output latency, and `a` is never a cycle behind `level`.
- **Command dropped or changed mid-count:** the prescaler restarts, so no partial step is carried over. For example, FILL held for `TICK_DIV-1` edges produces no step.
- **Direction reversal:** FILL changed to DRAIN at edge j gives the first drain step at edge j+`TICK_DIV`.
- **Reset mid-operation:** asynchronous assert forces the reset values immediately. After deassert, the first step needs a fresh command and the full `TICK_DIV` edges.
- **`level_chg`:** high for exactly one cycle per change; never high in IDLE.

## Test plan (`TICK_DIV`=4)
- Reset check: assert `rst` between edges.
  - Required: `a`=8'h01, `level`=0 and all flags 0 immediately, without waiting for an edge.
- Fill ramp: hold `fill` from edge 0 for 28 cycles.
  - Required: `level` steps to 1..7 at edges 4, 8, …, 28; `a` goes 8'h02 … 8'h80; seven `level_chg` pulses; `a`=8'h10 at edge 16.
- Overflow: continue `fill` at `level` 7 for 4 more edges.
  - Required: `overflow`=1 at edge 32; `level` stays 7; no `level_chg`.
  - Then hold `drain` for 4 edges. Required: `level`=6, `a`=8'h40, `overflow`=0.
- Underflow: from `level` 0, hold `drain` for 4 edges.
  - Required: `underflow`=1, `a`=8'h01.
  - Then `fill` for 4 edges. Required: `level`=1, `underflow`=0.
- Cancel and restart: apply `fill`=`drain`=1 for 10 cycles.
  - Required: no step.
  - Then `fill` for 3 cycles, drop for 1, `fill` for 3 cycles. Required: no step.
  - Then `fill` for 4 cycles. Required: exactly one step.
- Async reset mid-ramp: assert `rst` at `level` 5 with prescaler at 2.
  - Required: immediate `level`=0 and `a`=8'h01.
  - Required: after release with `fill` held, the first step comes exactly 4 edges after the first sampled edge.
